acq_step_sequencer: RTL and testbench
=====================================

ACQ_STEP_SEQUENCER -- requirements
Module: acq_step_sequencer

Interface
REQ-001 SHALL have parameter STEP_PULSE_CYCLES, default 16, meaning FD_STEP high time in CLK_MASTER cycles (min 1).
REQ-002 SHALL have ports (name direction width meaning):
 CLK_MASTER in 1 master clock; single clock domain
 RESET_N in 1 asynchronous active-low reset
 TICK_250US in 1 one-cycle strobe every 250us, CLK_MASTER-synchronous
 SEQ_GO in 1 start sequence (level, sampled in IDLE/DONE)
 SEQ_ABORT in 1 abort sequence (level)
 TRACK_COUNT in 8 tracks to acquire
 DOUBLE_STEP in 1 0=1 step per track, 1=2 steps per track
 STEP_DIR in 1 head direction, passed to FD_DIR
 STEP_RATE in 8 inter-step gap, 250us ticks
 SETTLE_TIME in 8 post-step settle, 250us ticks
 ACQ_WAITING in 1 from acquisition control: waiting for trigger
 ACQ_ACQUIRING in 1 from acquisition control: acquiring
 SR_R_FULL in 1 sample RAM full
 ACQ_START out 1 one-cycle start strobe to acquisition control
 ACQ_ABORT out 1 one-cycle abort strobe to acquisition control
 FD_STEP out 1 step pulse to drive, active high
 FD_DIR out 1 registered STEP_DIR
 TRACK_NUM out 8 0-based index of current track
 BUSY out 1 sequence in progress
 DONE out 1 sequence completed normally (level)
 ERR_FULL out 1 sequence ended by RAM full (level)

Function
REQ-003 SHALL implement states IDLE, START_ACQ, WAIT_BEGIN, WAIT_END, STEP_HI, STEP_GAP, SETTLE, FINISH.
REQ-004 IDLE/FINISH: SEQ_GO=1 -> latch TRACK_COUNT, DOUBLE_STEP, STEP_DIR, STEP_RATE, SETTLE_TIME; clear DONE, ERR_FULL; TRACK_NUM<=0; next START_ACQ (TRACK_COUNT=0 -> FINISH, DONE=1, no ACQ_START).
REQ-005 START_ACQ: ACQ_START=1 exactly one cycle; next WAIT_BEGIN.
REQ-006 WAIT_BEGIN: ACQ_WAITING|ACQ_ACQUIRING=1 -> WAIT_END; else stay.
REQ-007 WAIT_END: both low -> if SR_R_FULL seen any cycle during WAIT_BEGIN/WAIT_END -> FINISH, ERR_FULL=1, DONE=0; else if TRACK_NUM==latched count-1 -> FINISH, DONE=1; else STEP_HI with step counter = 1 or 2.
REQ-008 STEP_HI: FD_STEP=1 for exactly STEP_PULSE_CYCLES cycles; next STEP_GAP.
REQ-009 STEP_GAP: exit on Nth TICK_250US after entry, N=max(STEP_RATE,1); step counter-1; if nonzero -> STEP_HI, else SETTLE.
REQ-010 SETTLE: exit on Nth TICK after entry, N=SETTLE_TIME (0 -> exit next cycle); TRACK_NUM+1; next START_ACQ.
REQ-011 Tick counting: a TICK coincident with state entry SHALL not count.
REQ-012 TRACK_NUM SHALL be 8-bit; TRACK_COUNT=255 reaches TRACK_NUM 254 max; no wrap.
REQ-013 SEQ_ABORT=1 in any non-IDLE state SHALL override all else: ACQ_ABORT=1 one cycle, FD_STEP=0 same edge, next IDLE, DONE=0, ERR_FULL=0, TRACK_NUM holds.
REQ-014 SEQ_ABORT and SEQ_GO together SHALL yield no start, no ACQ_ABORT from IDLE/FINISH.
REQ-015 BUSY=1 in all states except IDLE and FINISH.
REQ-016 All outputs SHALL be registered; FD_DIR updates only on REQ-004 latch.
REQ-017 Input changes after latch SHALL not affect current sequence.

Reset
REQ-018 RESET_N=0 SHALL asynchronously force IDLE and all outputs 0, counters 0.
REQ-019 Reset mid-step SHALL drop FD_STEP immediately; no ACQ_ABORT strobe issued.

Structure
REQ-020 State encoding and STEP_PULSE_CYCLES default SHALL live in shared package acq_seq_pkg.
REQ-021 Tick-based delay SHALL be one sub-module acq_seq_tick_timer (load N, count TICK_250US, done flag).

Verification
REQ-022 TRACK_COUNT=3, DOUBLE_STEP=0, STEP_RATE=2, SETTLE_TIME=4; acq ACQUIRING 100 cycles each -> 3 ACQ_START, 2 FD_STEP pulses 16 cycles wide, TRACK_NUM 0,1,2, DONE=1.
REQ-023 TRACK_COUNT=2, DOUBLE_STEP=1, STEP_RATE=0 -> 2 FD_STEP pulses, gap exactly 1 tick, then SETTLE, 2 ACQ_START.
REQ-024 TRACK_COUNT=5, SR_R_FULL pulse during track 1 acquisition -> FINISH after track 1, ERR_FULL=1, DONE=0, TRACK_NUM=1, no further steps.
REQ-025 SEQ_ABORT during STEP_HI cycle 5 -> FD_STEP low next edge, ACQ_ABORT one cycle, BUSY=0, DONE=0.
REQ-026 TRACK_COUNT=0 -> DONE=1 one cycle after SEQ_GO, zero ACQ_START.
REQ-027 RESET_N low during WAIT_END -> all outputs 0 without clock; SEQ_GO after release restarts at TRACK_NUM=0.

Source files
------------

// File: rtl/acq_seq_pkg.sv
// Shared definitions for the acquisition step sequencer.
//   seq_state_e           : sequencer FSM state encoding
//   STEP_PULSE_CYCLES_DEF : default FD_STEP high time in CLK_MASTER cycles
//   min1()                : clamp an 8-bit tick count to at least 1
package acq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_ACQ,
    ST_WAIT_BEGIN,
    ST_WAIT_END,
    ST_STEP_HI,
    ST_STEP_GAP,
    ST_SETTLE,
    ST_FINISH
  } seq_state_e;

  localparam int STEP_PULSE_CYCLES_DEF = 16;

  function automatic logic [7:0] min1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/acq_seq_tick_timer.sv
// Counts 250us ticks down from a loaded value.
//   clk, rst_n : clock, async active-low reset
//   load, n    : load the tick count n (a tick in the load cycle is ignored)
//   tick       : one-cycle 250us strobe
//   done       : combinational; high when the count is already 0, or when
//                the tick that takes it from 1 to 0 is present this cycle
module acq_seq_tick_timer
  import acq_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] n,
  input  logic       tick,
  output logic       done
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = n;
    else if (tick && cnt_q != 0) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == 8'd0) || (tick && cnt_q == 8'd1);

endmodule

// File: rtl/acq_step_sequencer.sv
// Multi-track acquisition sequencer: for each track, start acquisition,
// wait for it to complete, then step the floppy head (1 or 2 pulses) with
// a tick-timed gap and settle before the next track.
//   CLK_MASTER, RESET_N : clock, async active-low reset
//   TICK_250US          : 250us strobe used for gap/settle timing
//   SEQ_GO / SEQ_ABORT  : start (latches config) / abort the sequence
//   TRACK_COUNT .. SETTLE_TIME : sequence configuration
//   ACQ_WAITING/ACQUIRING/SR_R_FULL : acquisition control status
//   ACQ_START/ACQ_ABORT : one-cycle strobes to acquisition control
//   FD_STEP, FD_DIR     : drive step pulse and direction
//   TRACK_NUM, BUSY, DONE, ERR_FULL : status (all registered)
module acq_step_sequencer
  import acq_seq_pkg::*;
#(
  parameter int STEP_PULSE_CYCLES = STEP_PULSE_CYCLES_DEF
) (
  input  logic       CLK_MASTER,
  input  logic       RESET_N,
  input  logic       TICK_250US,
  input  logic       SEQ_GO,
  input  logic       SEQ_ABORT,
  input  logic [7:0] TRACK_COUNT,
  input  logic       DOUBLE_STEP,
  input  logic       STEP_DIR,
  input  logic [7:0] STEP_RATE,
  input  logic [7:0] SETTLE_TIME,
  input  logic       ACQ_WAITING,
  input  logic       ACQ_ACQUIRING,
  input  logic       SR_R_FULL,
  output logic       ACQ_START,
  output logic       ACQ_ABORT,
  output logic       FD_STEP,
  output logic       FD_DIR,
  output logic [7:0] TRACK_NUM,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR_FULL
);

  localparam int PW = (STEP_PULSE_CYCLES > 1) ? $clog2(STEP_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(STEP_PULSE_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [7:0]    track_q, track_d, tc_q, tc_d, rate_q, rate_d, settle_q, settle_d;
  logic          dbl_q, dbl_d, dir_q, dir_d, done_q, done_d, err_q, err_d;
  logic          full_seen_q, full_seen_d;
  logic [1:0]    step_cnt_q, step_cnt_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          acq_start_q, acq_abort_q, acq_abort_d, fd_step_q, busy_q;
  logic          tmr_load, tmr_done;
  logic [7:0]    tmr_n;
  logic          abort_hit;

  acq_seq_tick_timer u_tmr (
    .clk   (CLK_MASTER),
    .rst_n (RESET_N),
    .load  (tmr_load),
    .n     (tmr_n),
    .tick  (TICK_250US),
    .done  (tmr_done)
  );

  // Abort only acts on an active sequence; IDLE/FINISH ignore it.
  assign abort_hit = SEQ_ABORT && (state_q != ST_IDLE) && (state_q != ST_FINISH);

  always_comb begin
    state_d     = state_q;
    track_d     = track_q;
    tc_d        = tc_q;
    dbl_d       = dbl_q;
    dir_d       = dir_q;
    rate_d      = rate_q;
    settle_d    = settle_q;
    done_d      = done_q;
    err_d       = err_q;
    full_seen_d = full_seen_q;
    step_cnt_d  = step_cnt_q;
    pulse_d     = pulse_q;
    tmr_load    = 1'b0;
    tmr_n       = settle_q;
    acq_abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (SEQ_GO && !SEQ_ABORT) begin
          tc_d     = TRACK_COUNT;
          dbl_d    = DOUBLE_STEP;
          dir_d    = STEP_DIR;
          rate_d   = STEP_RATE;
          settle_d = SETTLE_TIME;
          done_d   = 1'b0;
          err_d    = 1'b0;
          track_d  = 8'd0;
          if (TRACK_COUNT == 8'd0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_START_ACQ;
          end
        end
      end
      ST_START_ACQ: begin
        full_seen_d = 1'b0;
        state_d     = ST_WAIT_BEGIN;
      end
      ST_WAIT_BEGIN: begin
        if (SR_R_FULL) full_seen_d = 1'b1;
        if (ACQ_WAITING || ACQ_ACQUIRING) state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (SR_R_FULL) full_seen_d = 1'b1;
        if (!ACQ_WAITING && !ACQ_ACQUIRING) begin
          // RAM-full in this cycle counts as seen as well.
          if (full_seen_q || SR_R_FULL) begin
            state_d = ST_FINISH;
            err_d   = 1'b1;
            done_d  = 1'b0;
          end else if (track_q == tc_q - 8'd1) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_STEP_HI;
            step_cnt_d = dbl_q ? 2'd2 : 2'd1;
            pulse_d    = PULSE_LAST;
          end
        end
      end
      ST_STEP_HI: begin
        if (pulse_q == '0) begin
          state_d  = ST_STEP_GAP;
          tmr_load = 1'b1;
          tmr_n    = min1(rate_q);
        end else begin
          pulse_d = pulse_q - PW'(1);
        end
      end
      ST_STEP_GAP: begin
        if (tmr_done) begin
          step_cnt_d = step_cnt_q - 2'd1;
          if (step_cnt_q != 2'd1) begin
            state_d = ST_STEP_HI;
            pulse_d = PULSE_LAST;
          end else begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_n    = settle_q;
          end
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          track_d = track_q + 8'd1;
          state_d = ST_START_ACQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      err_d       = 1'b0;
      track_d     = track_q;
      tmr_load    = 1'b0;
      acq_abort_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      track_q     <= '0;
      tc_q        <= '0;
      dbl_q       <= 1'b0;
      dir_q       <= 1'b0;
      rate_q      <= '0;
      settle_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      full_seen_q <= 1'b0;
      step_cnt_q  <= '0;
      pulse_q     <= '0;
      acq_start_q <= 1'b0;
      acq_abort_q <= 1'b0;
      fd_step_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      track_q     <= track_d;
      tc_q        <= tc_d;
      dbl_q       <= dbl_d;
      dir_q       <= dir_d;
      rate_q      <= rate_d;
      settle_q    <= settle_d;
      done_q      <= done_d;
      err_q       <= err_d;
      full_seen_q <= full_seen_d;
      step_cnt_q  <= step_cnt_d;
      pulse_q     <= pulse_d;
      // Strobes/levels registered from the next state so they align with it.
      acq_start_q <= (state_d == ST_START_ACQ);
      acq_abort_q <= acq_abort_d;
      fd_step_q   <= (state_d == ST_STEP_HI);
      busy_q      <= (state_d != ST_IDLE) && (state_d != ST_FINISH);
    end
  end

  assign ACQ_START = acq_start_q;
  assign ACQ_ABORT = acq_abort_q;
  assign FD_STEP   = fd_step_q;
  assign FD_DIR    = dir_q;
  assign TRACK_NUM = track_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR_FULL  = err_q;

endmodule

// File: tb/tb_acq_step_sequencer.sv
// Directed bench for acq_step_sequencer: a tick generator, an acquisition
// responder, and a monitor that checks ACQ_START track numbers against a
// queue of expected tracks, FD_STEP widths, and tick counts in gaps.
module tb_acq_step_sequencer;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TICK_250US = 1'b0;
  logic       SEQ_GO = 1'b0, SEQ_ABORT = 1'b0;
  logic [7:0] TRACK_COUNT = '0, STEP_RATE = '0, SETTLE_TIME = '0;
  logic       DOUBLE_STEP = 1'b0, STEP_DIR = 1'b0;
  logic       ACQ_WAITING = 1'b0, ACQ_ACQUIRING = 1'b0, SR_R_FULL = 1'b0;
  logic       ACQ_START, ACQ_ABORT, FD_STEP, FD_DIR, BUSY, DONE, ERR_FULL;
  logic [7:0] TRACK_NUM;

  always #5 clk = ~clk;

  acq_step_sequencer dut (
    .CLK_MASTER(clk), .RESET_N(RESET_N), .TICK_250US(TICK_250US),
    .SEQ_GO(SEQ_GO), .SEQ_ABORT(SEQ_ABORT), .TRACK_COUNT(TRACK_COUNT),
    .DOUBLE_STEP(DOUBLE_STEP), .STEP_DIR(STEP_DIR), .STEP_RATE(STEP_RATE),
    .SETTLE_TIME(SETTLE_TIME), .ACQ_WAITING(ACQ_WAITING),
    .ACQ_ACQUIRING(ACQ_ACQUIRING), .SR_R_FULL(SR_R_FULL),
    .ACQ_START(ACQ_START), .ACQ_ABORT(ACQ_ABORT), .FD_STEP(FD_STEP),
    .FD_DIR(FD_DIR), .TRACK_NUM(TRACK_NUM), .BUSY(BUSY), .DONE(DONE),
    .ERR_FULL(ERR_FULL)
  );

  int vecs = 0, errs = 0;
  int exp_q[$];
  int acq_len = 100, full_track = -1;
  int exp_gap = 0, exp_post = 0;
  int starts = 0, pulses = 0, width = 0, gap_ticks = 0, post_ticks = 0;
  logic in_gap = 1'b0, post_arm = 1'b0, fd_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 250us tick every 8 cycles
  initial forever begin
    repeat (7) @(posedge clk);
    #1 TICK_250US = 1'b1;
    @(posedge clk);
    #1 TICK_250US = 1'b0;
  end

  // Acquisition control model: waiting 3 cycles, then acquiring acq_len.
  initial forever begin
    @(posedge clk); #1;
    if (ACQ_START) begin
      ACQ_WAITING = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      ACQ_WAITING = 1'b0;
      ACQ_ACQUIRING = 1'b1;
      for (int i = 0; i < acq_len; i++) begin
        SR_R_FULL = (i == 10 && int'(TRACK_NUM) == full_track);
        @(posedge clk); #1;
      end
      SR_R_FULL = 1'b0;
      ACQ_ACQUIRING = 1'b0;
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (ACQ_START) begin
      starts++;
      if (post_arm && exp_post != 0) chk("post_ticks", post_ticks, exp_post);
      post_arm = 1'b0;
      in_gap = 1'b0;
      chk("start_track", TRACK_NUM, (exp_q.size() > 0) ? exp_q.pop_front() : 999);
    end
    if (FD_STEP) begin
      if (!fd_prev) begin
        pulses++;
        if (in_gap && exp_gap != 0) chk("gap_ticks", gap_ticks, exp_gap);
        width = 0;
      end
      width++;
    end else if (fd_prev) begin
      if (!ACQ_ABORT) chk("pulse_width", width, 16);
      in_gap = 1'b1; gap_ticks = 0;
      post_arm = 1'b1; post_ticks = 0;
    end
    if (!FD_STEP && TICK_250US) begin
      gap_ticks++;
      post_ticks++;
    end
    fd_prev = FD_STEP;
  end

  task automatic go();
    @(posedge clk); #1 SEQ_GO = 1'b1;
    @(posedge clk); #1 SEQ_GO = 1'b0;
  endtask

  task automatic cfg(input int tc, input bit dbl, input bit dir, input int rate,
                     input int settle, input int alen);
    TRACK_COUNT = 8'(tc); DOUBLE_STEP = dbl; STEP_DIR = dir;
    STEP_RATE = 8'(rate); SETTLE_TIME = 8'(settle); acq_len = alen;
    starts = 0; pulses = 0; in_gap = 1'b0; post_arm = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(DONE || ERR_FULL) && n < budget) begin @(negedge clk); n++; end
    chk("end_timeout", 32'(DONE || ERR_FULL), 1);
    @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", BUSY, 0);
    chk("rst_outs", {ACQ_START, ACQ_ABORT, FD_STEP, FD_DIR, DONE, ERR_FULL}, 0);
    chk("rst_track", TRACK_NUM, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);

    // 3 tracks, single step; inputs changed after latch must be ignored
    cfg(3, 0, 1, 2, 4, 100); exp_post = 6; exp_gap = 0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    go();
    TRACK_COUNT = 8'd9; STEP_DIR = 1'b0;
    @(negedge clk);
    chk("s1_busy", BUSY, 1);
    wait_end(3000);
    chk("s1_done", DONE, 1); chk("s1_err", ERR_FULL, 0);
    chk("s1_track", TRACK_NUM, 2); chk("s1_starts", starts, 3);
    chk("s1_pulses", pulses, 2); chk("s1_dir", FD_DIR, 1);
    chk("s1_busy_end", BUSY, 0); chk("s1_q", exp_q.size(), 0);

    // 2 tracks, double step, rate 0 -> 1-tick gap, settle 0
    cfg(2, 1, 0, 0, 0, 20); exp_post = 0; exp_gap = 1;
    exp_q.push_back(0); exp_q.push_back(1);
    go();
    wait_end(2000);
    chk("s2_done", DONE, 1); chk("s2_track", TRACK_NUM, 1);
    chk("s2_starts", starts, 2); chk("s2_pulses", pulses, 2);
    chk("s2_dir", FD_DIR, 0);

    // RAM full during track 1
    cfg(5, 0, 1, 1, 1, 30); exp_post = 2; exp_gap = 0; full_track = 1;
    exp_q.push_back(0); exp_q.push_back(1);
    go();
    wait_end(2000);
    full_track = -1;
    chk("s3_err", ERR_FULL, 1); chk("s3_done", DONE, 0);
    chk("s3_track", TRACK_NUM, 1); chk("s3_starts", starts, 2);
    chk("s3_pulses", pulses, 1);
    repeat (40) @(negedge clk);
    chk("s3_no_more", pulses, 1);

    // abort during STEP_HI cycle 5
    cfg(4, 0, 1, 1, 1, 20); exp_post = 0;
    exp_q.push_back(0);
    go();
    begin
      int n = 0;
      while (!FD_STEP && n < 500) begin @(negedge clk); n++; end
      chk("s4_step_seen", FD_STEP, 1);
    end
    repeat (4) @(negedge clk);
    chk("s4_hi5", FD_STEP, 1);
    SEQ_ABORT = 1'b1;
    @(negedge clk);
    chk("s4_step_off", FD_STEP, 0); chk("s4_abort", ACQ_ABORT, 1);
    chk("s4_busy", BUSY, 0); chk("s4_done", DONE, 0);
    chk("s4_track", TRACK_NUM, 0);
    SEQ_ABORT = 1'b0;
    @(negedge clk);
    chk("s4_abort_1cyc", ACQ_ABORT, 0);
    // GO together with ABORT in IDLE: nothing happens
    starts = 0;
    SEQ_GO = 1'b1; SEQ_ABORT = 1'b1;
    repeat (3) @(negedge clk);
    chk("s4b_busy", BUSY, 0); chk("s4b_abort", ACQ_ABORT, 0);
    SEQ_GO = 1'b0; SEQ_ABORT = 1'b0;
    repeat (2) @(negedge clk);
    chk("s4b_starts", starts, 0);

    // zero tracks: DONE one cycle after GO, no start
    cfg(0, 0, 0, 1, 1, 20);
    @(posedge clk); #1 SEQ_GO = 1'b1;
    @(posedge clk); #1 SEQ_GO = 1'b0;
    @(negedge clk);
    chk("s5_done", DONE, 1); chk("s5_busy", BUSY, 0);
    repeat (5) @(negedge clk);
    chk("s5_starts", starts, 0);

    // reset during WAIT_END of track 1, then restart from track 0
    cfg(3, 0, 1, 1, 1, 100);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    go();
    begin
      int n = 0;
      while (starts < 2 && n < 2000) begin @(negedge clk); n++; end
      chk("s6_start2", starts, 2);
    end
    repeat (20) @(negedge clk);
    chk("s6_pre_track", TRACK_NUM, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("s6_rst_outs", {ACQ_START, ACQ_ABORT, FD_STEP, FD_DIR, BUSY, DONE, ERR_FULL}, 0);
    chk("s6_rst_track", TRACK_NUM, 0);
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    repeat (130) @(negedge clk);
    exp_q.delete();
    cfg(2, 0, 0, 1, 1, 20);
    exp_q.push_back(0); exp_q.push_back(1);
    go();
    wait_end(2000);
    chk("s6_done", DONE, 1); chk("s6_track", TRACK_NUM, 1);
    chk("s6_starts", starts, 2); chk("s6_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
